// File: rtl/nios_led_blink_driver.sv
// -----------------------------------------------------------------------------
// nios_led_blink_driver
//
// Turns the 2-bit LED PIO mode code into a single LED drive pattern:
//   00 = off, 01 = on, 10 = fixed-rate blink, 11 = PWM "breathing".
// Any change of the mode code restarts the prescaler, blink, PWM and ramp
// state, so a mode always begins at the same, known pattern phase.
//
// Ports:
//   clk      in   system clock, all state on the rising edge
//   reset    in   asynchronous, active-high reset
//   mode     in   [1:0] mode code from the PIO out_port (synchronous to clk)
//   led_out  out  registered LED drive, 1 = lit
//   tick     out  registered one-cycle strobe at each prescaler wrap
//   duty     out  [PWM_BITS-1:0] current breathing duty (status/debug)
// -----------------------------------------------------------------------------
module nios_led_blink_driver #(
  parameter int TICK_DIV    = 50000,
  parameter int BLINK_TICKS = 250,
  parameter int RAMP_TICKS  = 8,
  parameter int PWM_BITS    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  output logic                led_out,
  output logic                tick,
  output logic [PWM_BITS-1:0] duty
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Counter widths; a terminal count of 0 still needs a 1-bit register.
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int RW = (RAMP_TICKS  > 1) ? $clog2(RAMP_TICKS)  : 1;

  localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [RW-1:0]       RAMP_LAST  = RW'(RAMP_TICKS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = {PWM_BITS{1'b1}};

  // Registered state
  mode_t               r_mode_q;
  logic [PW-1:0]       r_presc;
  logic [BW-1:0]       r_blink_cnt;
  logic                r_blink_state;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [RW-1:0]       r_ramp_cnt;
  dir_t                r_dir;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_led;
  logic                r_tick;

  // Next-state values
  mode_t               w_mode_q_nxt;
  logic [PW-1:0]       w_presc_nxt;
  logic [BW-1:0]       w_blink_cnt_nxt;
  logic                w_blink_state_nxt;
  logic [PWM_BITS-1:0] w_pwm_cnt_nxt;
  logic [RW-1:0]       w_ramp_cnt_nxt;
  dir_t                w_dir_nxt;
  logic [PWM_BITS-1:0] w_duty_nxt;
  logic                w_led_nxt;
  logic                w_tick_nxt;

  logic w_chg;
  logic w_tk;

  assign w_chg = (mode != r_mode_q);
  assign w_tk  = (r_presc == PRESC_LAST);

  always_comb begin
    // NOTE: every next-state value starts as "hold", so no path through the
    // case statement below can leave a signal unassigned and infer a latch.
    w_mode_q_nxt      = r_mode_q;
    w_presc_nxt       = r_presc;
    w_blink_cnt_nxt   = r_blink_cnt;
    w_blink_state_nxt = r_blink_state;
    w_pwm_cnt_nxt     = r_pwm_cnt;
    w_ramp_cnt_nxt    = r_ramp_cnt;
    w_dir_nxt         = r_dir;
    w_duty_nxt        = r_duty;
    w_led_nxt         = r_led;
    w_tick_nxt        = 1'b0;

    if (w_chg) begin
      // Restart every pattern generator; a coincident tick is discarded.
      w_mode_q_nxt      = mode_t'(mode);
      w_presc_nxt       = '0;
      w_blink_cnt_nxt   = '0;
      w_blink_state_nxt = 1'b1;
      w_pwm_cnt_nxt     = '0;
      w_ramp_cnt_nxt    = '0;
      w_dir_nxt         = DIR_UP;
      w_duty_nxt        = '0;
      w_led_nxt         = (mode == MODE_ON) || (mode == MODE_BLINK);
    end else begin
      // The prescaler runs in every mode so tick is always available.
      w_presc_nxt = w_tk ? '0 : r_presc + PW'(1);
      w_tick_nxt  = w_tk;

      unique case (r_mode_q)
        MODE_OFF: w_led_nxt = 1'b0;
        MODE_ON:  w_led_nxt = 1'b1;
        MODE_BLINK: begin
          if (w_tk) begin
            if (r_blink_cnt == BLINK_LAST) begin
              w_blink_cnt_nxt   = '0;
              w_blink_state_nxt = ~r_blink_state;
            end else begin
              w_blink_cnt_nxt = r_blink_cnt + BW'(1);
            end
          end
          w_led_nxt = w_blink_state_nxt;
        end
        MODE_BREATHE: begin
          w_pwm_cnt_nxt = r_pwm_cnt + PWM_BITS'(1);
          w_led_nxt     = (r_pwm_cnt < r_duty);
          if (w_tk) begin
            if (r_ramp_cnt == RAMP_LAST) begin
              w_ramp_cnt_nxt = '0;
              // Bounce at the end stops instead of wrapping the duty.
              if (r_dir == DIR_UP) begin
                if (r_duty == DUTY_MAX) begin
                  w_dir_nxt  = DIR_DOWN;
                  w_duty_nxt = r_duty - PWM_BITS'(1);
                end else begin
                  w_duty_nxt = r_duty + PWM_BITS'(1);
                end
              end else begin
                if (r_duty == '0) begin
                  w_dir_nxt  = DIR_UP;
                  w_duty_nxt = r_duty + PWM_BITS'(1);
                end else begin
                  w_duty_nxt = r_duty - PWM_BITS'(1);
                end
              end
            end else begin
              w_ramp_cnt_nxt = r_ramp_cnt + RW'(1);
            end
          end
        end
        default: w_led_nxt = 1'b0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode_q      <= MODE_OFF;
      r_presc       <= '0;
      r_blink_cnt   <= '0;
      r_blink_state <= 1'b1;
      r_pwm_cnt     <= '0;
      r_ramp_cnt    <= '0;
      r_dir         <= DIR_UP;
      r_duty        <= '0;
      r_led         <= 1'b0;
      r_tick        <= 1'b0;
    end else begin
      r_mode_q      <= w_mode_q_nxt;
      r_presc       <= w_presc_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_state <= w_blink_state_nxt;
      r_pwm_cnt     <= w_pwm_cnt_nxt;
      r_ramp_cnt    <= w_ramp_cnt_nxt;
      r_dir         <= w_dir_nxt;
      r_duty        <= w_duty_nxt;
      r_led         <= w_led_nxt;
      r_tick        <= w_tick_nxt;
    end
  end

  assign led_out = r_led;
  assign tick    = r_tick;
  assign duty    = r_duty;

endmodule

// File: tb/tb_nios_led_blink_driver.sv
// -----------------------------------------------------------------------------
// tb_nios_led_blink_driver
//
// Directed bench for nios_led_blink_driver with TICK_DIV=4, BLINK_TICKS=2,
// RAMP_TICKS=1, PWM_BITS=2. The driver pushes the expected led_out/tick/duty
// for each upcoming edge into a queue; the monitor pops and compares on the
// falling edge of the matching cycle.
// -----------------------------------------------------------------------------
module tb_nios_led_blink_driver;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode  = 2'b00;
  logic       led_out;
  logic       tick;
  logic [1:0] duty;

  nios_led_blink_driver #(
    .TICK_DIV   (4),
    .BLINK_TICKS(2),
    .RAMP_TICKS (1),
    .PWM_BITS   (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .led_out(led_out),
    .tick   (tick),
    .duty   (duty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         n;
    string      tag;
    logic       led;
    logic       tk;
    logic [1:0] duty;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   base    = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected value for edge n of the current phase (edge 0 = base+1).
  task automatic push(input string tag, input int n, input logic led,
                      input logic tk, input logic [1:0] d);
    exp_t e;
    e.cyc = base + 1 + n; e.n = n; e.tag = tag;
    e.led = led; e.tk = tk; e.duty = d;
    q.push_back(e);
  endtask

  // Breathing duty per tick index: 0,1,2,3,2,1 then repeats.
  function automatic logic [1:0] seq_duty(input int i);
    case (i % 6)
      0: return 2'd0;
      1: return 2'd1;
      2: return 2'd2;
      3: return 2'd3;
      4: return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  // Blink after a restart at edge m=0: lit 8 cycles, dark 8 cycles.
  function automatic logic blink_led(input int m);
    return ((m / 8) % 2) == 0;
  endfunction

  function automatic logic tick_after_chg(input int m);
    return (m > 0) && (m % 4 == 0);
  endfunction

  // Breathe after a restart at edge n=0; led lags the pwm/duty compare by one.
  function automatic logic breathe_led(input int n);
    if (n == 0) return 1'b0;
    return ((n - 1) % 4) < int'(seq_duty((n - 1) / 4));
  endfunction

  // Monitor: compare every expectation on the falling edge of its cycle.
  exp_t mon_e;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.cyc < cyc) begin
        check($sformatf("%s@%0d missed", mon_e.tag, mon_e.n), 8'(cyc), 8'(mon_e.cyc));
      end else begin
        check($sformatf("%s@%0d led",  mon_e.tag, mon_e.n), 8'(led_out), 8'(mon_e.led));
        check($sformatf("%s@%0d tick", mon_e.tag, mon_e.n), 8'(tick),    8'(mon_e.tk));
        check($sformatf("%s@%0d duty", mon_e.tag, mon_e.n), 8'(duty),    8'(mon_e.duty));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset led",  8'(led_out), 8'd0);
    check("reset tick", 8'(tick),    8'd0);
    check("reset duty", 8'(duty),    8'd0);
    reset = 1'b0;

    // OFF with no change: prescaler runs from 0, first tick on the 4th edge.
    base = cyc;
    for (int n = 0; n < 20; n++) push("off", n, 1'b0, ((n + 1) % 4) == 0, 2'd0);
    repeat (20) @(posedge clk);
    #1;

    // ON: lit from the change edge, tick 4 edges later.
    base = cyc; mode = 2'b01;
    for (int n = 0; n < 12; n++) push("on", n, 1'b1, tick_after_chg(n), 2'd0);
    repeat (12) @(posedge clk);
    #1;

    // BLINK, then 10->01->10 glitch on a tick edge (n=36), then restarted blink.
    base = cyc; mode = 2'b10;
    for (int n = 0; n < 36; n++) push("blink", n, blink_led(n), tick_after_chg(n), 2'd0);
    push("glitch_on", 36, 1'b1, 1'b0, 2'd0);
    for (int m = 0; m < 24; m++) push("reblink", 37 + m, blink_led(m), tick_after_chg(m), 2'd0);
    repeat (36) @(posedge clk);
    #1 mode = 2'b01;
    @(posedge clk);
    #1 mode = 2'b10;
    repeat (24) @(posedge clk);
    #1;

    // BREATHE up to edge 41 (duty=2 on the way down), then async reset.
    base = cyc; mode = 2'b11;
    for (int n = 0; n < 42; n++) push("breathe", n, breathe_led(n), tick_after_chg(n), seq_duty(n / 4));
    repeat (42) @(posedge clk);
    #6;
    reset = 1'b1;
    #1;
    check("async_rst led",  8'(led_out), 8'd0);
    check("async_rst tick", 8'(tick),    8'd0);
    check("async_rst duty", 8'(duty),    8'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Mode held at 11: first edge after release is a change, ramp from 0 up.
    base = cyc;
    for (int n = 0; n < 20; n++) push("post_rst", n, breathe_led(n), tick_after_chg(n), seq_duty(n / 4));
    repeat (20) @(posedge clk);
    #6;

    check("queue drained", 8'(q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
